econ_out_serializer: RTL and testbench

Sink-side block for the ECON autoencoder core. It captures each wide `layer5_out` result word when the core pulses its valid (valid-only, no backpressure), buffers up to two frames, and serializes each frame into `NUM_OUT` narrow codes on a ready/valid stream toward the readout link. Loss is never silent: a third pending frame is dropped, flagged, and counted.

---
 rtl/econ_out_serializer.sv | 173 +++++++++++++++++
 tb/tb_econ_out_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/econ_out_serializer.sv
// Sink for the ECON core result word: 2-deep frame buffer feeding a ready/valid code serializer.
// Optional per-frame sequence header is enabled by defining ECON_OUT_SER_HDR_EN.
module econ_out_serializer #(
  parameter int NUM_OUT = 10,
  parameter int OUT_W   = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_OUT*OUT_W-1:0] layer5_out_rsc_dat,
  input  logic                     layer5_out_rsc_vld,
  output logic [OUT_W-1:0]         out_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_last,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int FRAME_W = NUM_OUT * OUT_W;
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

`ifdef ECON_OUT_SER_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [OUT_W-1:0]   out_dat_q;
  logic               out_vld_q;
  logic               out_last_q;
  logic               overflow_q;
  logic [7:0]         drop_cnt_q;

  logic [FRAME_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;

  logic               accept;
  logic               pop;
  logic               full;
  logic               push;
  logic               drop;
  logic               start;
  logic               src_from_fifo;
  logic               src_ptr;
  logic [IDX_W-1:0]   idx_inc;
  logic [OUT_W-1:0]   start_dat;
  logic               start_last;
  state_t             start_state;
  logic [OUT_W-1:0]   head_codes [NUM_OUT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_codes
      assign head_codes[gi] = mem_q[rd_ptr_q][gi*OUT_W +: OUT_W];
    end
  endgenerate

  // The final code's acceptance frees its slot in the same cycle, so a
  // coincident capture into a full buffer is not a drop.
  assign accept = out_vld_q & out_rdy;
  assign pop    = accept & out_last_q;
  assign full   = (cnt_q == 2'd2);
  assign push   = layer5_out_rsc_vld & (~full | pop);
  assign drop   = layer5_out_rsc_vld & full & ~pop;

  assign start   = (state_q == S_IDLE) ? ((cnt_q != 2'd0) | layer5_out_rsc_vld)
                                       : (pop & (full | push));
  assign idx_inc = idx_q + 1'b1;

  // The next frame comes from the buffer if one is already waiting, otherwise
  // straight from the input so an empty buffer adds no latency.
  assign src_from_fifo = (state_q == S_IDLE) ? (cnt_q != 2'd0) : full;
  assign src_ptr       = (state_q == S_IDLE) ? rd_ptr_q : ~rd_ptr_q;

`ifdef ECON_OUT_SER_HDR_EN
  logic [7:0] seq_q;
  logic [7:0] seq_mem_q [2];
  logic [7:0] new_seq;

  assign new_seq     = src_from_fifo ? seq_mem_q[src_ptr] : seq_q;
  assign start_dat   = {{(OUT_W-8){1'b0}}, new_seq};
  assign start_last  = 1'b0;
  assign start_state = S_HDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= 8'd0;
    end else begin
      if (layer5_out_rsc_vld) seq_q <= seq_q + 8'd1;
      if (push) seq_mem_q[wr_ptr_q] <= seq_q;
    end
  end
`else
  assign start_dat   = src_from_fifo ? mem_q[src_ptr][OUT_W-1:0]
                                     : layer5_out_rsc_dat[OUT_W-1:0];
  assign start_last  = (LAST_IDX == '0);
  assign start_state = S_DATA;
`endif

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= layer5_out_rsc_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else if (start) begin
      state_q    <= start_state;
      idx_q      <= '0;
      out_dat_q  <= start_dat;
      out_vld_q  <= 1'b1;
      out_last_q <= start_last;
    end else if (pop) begin
      state_q    <= S_IDLE;
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
`ifdef ECON_OUT_SER_HDR_EN
    end else if (accept && state_q == S_HDR) begin
      state_q    <= S_DATA;
      idx_q      <= '0;
      out_dat_q  <= head_codes[0];
      out_last_q <= (LAST_IDX == '0);
`endif
    end else if (accept) begin
      idx_q      <= idx_inc;
      out_dat_q  <= head_codes[idx_inc];
      out_last_q <= (idx_inc == LAST_IDX);
    end
  end

  assign out_dat  = out_dat_q;
  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_econ_out_serializer.sv
// Directed bench for econ_out_serializer: latency, backpressure, overflow, boundary capture, reset mid-frame.
// Expected streams include sequence headers when ECON_OUT_SER_HDR_EN is defined.
module tb_econ_out_serializer;
  localparam int NUM_OUT = 10;
  localparam int OUT_W   = 22;
`ifdef ECON_OUT_SER_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_OUT*OUT_W-1:0] dat;
  logic                     vld;
  logic [OUT_W-1:0]         out_dat;
  logic                     out_vld;
  logic                     out_rdy;
  logic                     out_last;
  logic                     overflow;
  logic [7:0]               drop_cnt;

  econ_out_serializer #(.NUM_OUT(NUM_OUT), .OUT_W(OUT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .layer5_out_rsc_dat (dat),
    .layer5_out_rsc_vld (vld),
    .out_dat            (out_dat),
    .out_vld            (out_vld),
    .out_rdy            (out_rdy),
    .out_last           (out_last),
    .overflow           (overflow),
    .drop_cnt           (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_err = 0;
  logic [7:0] tb_seq = 8'd0;

  logic [OUT_W-1:0] got_dat[$];
  bit               got_last[$];
  logic [OUT_W-1:0] exp_dat[$];
  bit               exp_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfer recorder and stall-stability monitor, sampled mid-cycle
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_dat;
  logic             prev_last;
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      if (!out_vld || out_dat !== prev_dat || out_last !== prev_last) hold_err++;
    end
    prev_stall = !rst && out_vld && !out_rdy;
    prev_dat   = out_dat;
    prev_last  = out_last;
    if (!rst && out_vld && out_rdy) begin
      got_dat.push_back(out_dat);
      got_last.push_back(out_last);
      $display("xfer %0d: dat=0x%06h last=%0d", got_dat.size() - 1, out_dat, out_last);
    end
  end

  function automatic logic [NUM_OUT*OUT_W-1:0] mk(input int base);
    logic [NUM_OUT*OUT_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_OUT; i++) f[i*OUT_W +: OUT_W] = OUT_W'(base + i + 1);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one capture pulse; the caller advances the clock.
  task automatic fire(input int base, input bit kept);
    dat = mk(base);
    vld = 1'b1;
    if (kept) begin
      if (HDR) begin
        exp_dat.push_back(OUT_W'(tb_seq));
        exp_last.push_back(1'b0);
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        exp_dat.push_back(OUT_W'(base + i + 1));
        exp_last.push_back(i == NUM_OUT - 1);
      end
    end
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!out_vld) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
    repeat (3) step();
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, 32'(got_dat.size()), 32'(exp_dat.size()));
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      chk($sformatf("%s_dat%0d", tag, i), 32'(got_dat[i]), 32'(exp_dat[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
    end
    got_dat.delete();
    got_last.delete();
    exp_dat.delete();
    exp_last.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b1; vld = 1'b0; out_rdy = 1'b0; dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_dat", 32'(out_dat), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    rst = 1'b0;

    // Single frame with first-code latency
    out_rdy = 1'b1;
    step();
    fire(0, 1'b1);
    @(negedge clk);
    chk("lat_pre_vld", 32'(out_vld), 32'd0);
    step();
    vld = 1'b0;
    @(negedge clk);
    chk("lat_vld", 32'(out_vld), 32'd1);
    chk("lat_dat", 32'(out_dat), HDR ? 32'd0 : 32'd1);
    wait_idle("t1");
    compare_stream("t1");

    // Backpressure pattern 1,0,0,1
    for (int k = 0; k < 60; k++) begin
      step();
      out_rdy = (k % 4 == 0) || (k % 4 == 3);
      if (k == 0) fire(32'h40, 1'b1);
      else vld = 1'b0;
    end
    out_rdy = 1'b1;
    wait_idle("t2");
    compare_stream("t2");

    // Overflow: A, B kept, C dropped, then drop counter saturation
    out_rdy = 1'b0;
    step(); fire(32'h100, 1'b1);
    step(); fire(32'h200, 1'b1);
    step(); fire(32'h300, 1'b0);
    step(); vld = 1'b0;
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop1", 32'(drop_cnt), 32'd1);
    for (int k = 0; k < 260; k++) begin
      step();
      fire(32'h900, 1'b0);
    end
    step(); vld = 1'b0;
    @(negedge clk);
    chk("ovf_sat", 32'(drop_cnt), 32'd255);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step();
    out_rdy = 1'b1;
    wait_idle("t3");
    compare_stream("t3");

    // Reset after four codes of a frame
    step(); fire(32'h500, 1'b1);
    step(); vld = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (got_dat.size() >= 4) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_reach4", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tb_seq = 8'd0;
    @(negedge clk);
    chk("rstmid_vld", 32'(out_vld), 32'd0);
    chk("rstmid_last", 32'(out_last), 32'd0);
    chk("rstmid_ovf", 32'(overflow), 32'd0);
    chk("rstmid_drop", 32'(drop_cnt), 32'd0);
    while (exp_dat.size() > 4) begin
      void'(exp_dat.pop_back());
      void'(exp_last.pop_back());
    end
    repeat (3) step();
    compare_stream("t5a");
    fire(32'h600, 1'b1);
    step(); vld = 1'b0;
    wait_idle("t5b");
    compare_stream("t5b");

    // Boundary: capture coincides with acceptance of A's last code while full
    out_rdy = 1'b0;
    step(); fire(32'h700, 1'b1);
    step(); fire(32'h800, 1'b1);
    step(); vld = 1'b0;
    step(); out_rdy = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_vld && out_rdy && out_last) begin
        found = 1'b1;
        break;
      end
    end
    chk("bnd_last_seen", 32'(found), 32'd1);
    fire(32'hA00, 1'b1);
    step(); vld = 1'b0;
    wait_idle("t4");
    chk("bnd_ovf", 32'(overflow), 32'd0);
    chk("bnd_drop", 32'(drop_cnt), 32'd0);
    compare_stream("t4");

    chk("hold_stable", 32'(hold_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
